// File: rtl/adv_video_timing_if.sv
// Upstream pixel stream into the ADV7513 timing stage: 24-bit {R,G,B} with
// valid/ready handshake. The framebuffer reader is the master.
interface adv_video_timing_if;
    logic [23:0] Pix_Data;
    logic        Pix_Valid;
    logic        Pix_Ready;

    modport master (
        output Pix_Data,
        output Pix_Valid,
        input  Pix_Ready
    );

    modport slave (
        input  Pix_Data,
        input  Pix_Valid,
        output Pix_Ready
    );
endinterface

// File: rtl/adv_video_timing.sv
// Video timing generator and registered pixel stage for the ADV7513 HDMI transmitter.
// Counters run from Enable; a stop request always finishes the current frame.
module adv_video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic                     Pixel_CLK,
    input  logic                     Reset_n,
    input  logic                     Enable,
    adv_video_timing_if.slave        pix,
    output logic                     Frame_Start,
    output logic [10:0]              Pos_X,
    output logic [9:0]               Pos_Y,
    output logic                     Underflow,
    input  logic                     Underflow_Clear,
    output logic                     ADV_DE,
    output logic                     ADV_Hsync,
    output logic                     ADV_Vsync,
    output logic [23:0]              ADV_D
);

    localparam logic [10:0] H_ACT_L   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT_L   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_S  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

    state_e      r_state, w_state_next;
    logic [10:0] r_pos_x, w_x_next, w_x_adv;
    logic [9:0]  r_pos_y, w_y_next, w_y_adv;
    logic        r_de, r_hsync, r_vsync, r_underflow;
    logic [23:0] r_d;

    logic w_running, w_active, w_last, w_xfer, w_hsync_on, w_vsync_on;

    assign w_running  = (r_state != StIdle);
    assign w_active   = w_running && (r_pos_x < H_ACT_L) && (r_pos_y < V_ACT_L);
    assign w_last     = (r_pos_x == H_LAST) && (r_pos_y == V_LAST);
    assign w_xfer     = w_active && pix.Pix_Valid;
    assign w_hsync_on = w_running && (r_pos_x >= H_SYNC_S) && (r_pos_x < H_SYNC_E);
    assign w_vsync_on = w_running && (r_pos_y >= V_SYNC_S) && (r_pos_y < V_SYNC_E);

    assign w_x_adv = (r_pos_x == H_LAST) ? 11'd0 : r_pos_x + 11'd1;
    assign w_y_adv = (r_pos_x != H_LAST) ? r_pos_y :
                     (r_pos_y == V_LAST) ? 10'd0 : r_pos_y + 10'd1;

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_pos_x;
        w_y_next     = r_pos_y;
        unique case (r_state)
            StIdle: begin
                w_x_next = 11'd0;
                w_y_next = 10'd0;
                if (Enable) w_state_next = StRun;
            end
            StRun: begin
                // Dropping Enable on the very last pixel ends the frame here rather
                // than starting an unrequested extra frame in StStopping.
                if (!Enable && w_last) begin
                    w_state_next = StIdle;
                    w_x_next     = 11'd0;
                    w_y_next     = 10'd0;
                end else begin
                    if (!Enable) w_state_next = StStopping;
                    w_x_next = w_x_adv;
                    w_y_next = w_y_adv;
                end
            end
            StStopping: begin
                if (Enable) begin
                    w_state_next = StRun;
                    w_x_next     = w_x_adv;
                    w_y_next     = w_y_adv;
                end else if (w_last) begin
                    w_state_next = StIdle;
                    w_x_next     = 11'd0;
                    w_y_next     = 10'd0;
                end else begin
                    w_x_next = w_x_adv;
                    w_y_next = w_y_adv;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_x_next     = 11'd0;
                w_y_next     = 10'd0;
            end
        endcase
    end

    always_ff @(posedge Pixel_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
            r_pos_x <= 11'd0;
            r_pos_y <= 10'd0;
        end else begin
            r_state <= w_state_next;
            r_pos_x <= w_x_next;
            r_pos_y <= w_y_next;
        end
    end

    always_ff @(posedge Pixel_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_de        <= 1'b0;
            r_hsync     <= ~HS_POL;
            r_vsync     <= ~VS_POL;
            r_d         <= 24'h000000;
            r_underflow <= 1'b0;
        end else begin
            r_de    <= w_active;
            r_hsync <= w_hsync_on ? HS_POL : ~HS_POL;
            r_vsync <= w_vsync_on ? VS_POL : ~VS_POL;
            r_d     <= w_xfer ? pix.Pix_Data : 24'h000000;
            // A new underflow takes priority over a clear in the same cycle.
            if (w_active && !pix.Pix_Valid) r_underflow <= 1'b1;
            else if (Underflow_Clear)       r_underflow <= 1'b0;
        end
    end

    assign pix.Pix_Ready = w_active;
    assign Frame_Start   = w_running && (r_pos_x == 11'd0) && (r_pos_y == 10'd0);
    assign Pos_X         = r_pos_x;
    assign Pos_Y         = r_pos_y;
    assign Underflow     = r_underflow;
    assign ADV_DE        = r_de;
    assign ADV_Hsync     = r_hsync;
    assign ADV_Vsync     = r_vsync;
    assign ADV_D         = r_d;

endmodule

// File: tb/tb_adv_video_timing.sv
// Directed bench for adv_video_timing on a reduced 15x8 raster (120 clocks per frame).
module tb_adv_video_timing;
    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 15, VT = 8, FRAME = 120;

    logic        clk = 1'b0;
    logic        rst_n, en, uclr;
    logic        fs, uf, de, hs, vs;
    logic [10:0] px;
    logic [9:0]  py;
    logic [23:0] dout;

    adv_video_timing_if pif();

    always #5 clk = ~clk;

    adv_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .Pixel_CLK(clk),
        .Reset_n(rst_n),
        .Enable(en),
        .pix(pif.slave),
        .Frame_Start(fs),
        .Pos_X(px),
        .Pos_Y(py),
        .Underflow(uf),
        .Underflow_Clear(uclr),
        .ADV_DE(de),
        .ADV_Hsync(hs),
        .ADV_Vsync(vs),
        .ADV_D(dout)
    );

    int checks = 0, errors = 0, cyc = 0;
    int m_run, mx, my;
    logic m_de, m_hs, m_vs, m_uf;
    logic [23:0] m_d, seq;
    int fs_last = -1, fs_count = 0, fs_gap = 0;
    bit count_en = 1'b0;
    int cnt_de = 0, cnt_hs = 0, cnt_vs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; mx = 0; my = 0;
        m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_d = 24'h0; m_uf = 1'b0;
    endtask

    // Called at a falling edge with this cycle's inputs applied.
    task automatic step();
        logic act, last;
        act = (m_run != 0) && (mx < HA) && (my < VA);
        chk("pix_ready", pif.Pix_Ready, act);
        chk("frame_start", fs, (m_run != 0) && mx == 0 && my == 0);
        chk("pos_x", px, mx);
        chk("pos_y", py, my);
        chk("adv_de", de, m_de);
        chk("adv_hsync", hs, m_hs);
        chk("adv_vsync", vs, m_vs);
        chk("adv_d", dout, m_d);
        chk("underflow", uf, m_uf);
        if (fs) begin
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last = cyc;
            fs_count++;
        end
        if (count_en) begin
            cnt_de += int'(de);
            cnt_hs += int'(!hs);
            cnt_vs += int'(!vs);
        end
        m_de = act;
        m_hs = !((m_run != 0) && mx >= HA + HF && mx < HA + HF + HS);
        m_vs = !((m_run != 0) && my >= VA + VF && my < VA + VF + VS);
        m_d  = (act && pif.Pix_Valid) ? pif.Pix_Data : 24'h0;
        m_uf = (act && !pif.Pix_Valid) ? 1'b1 : (uclr ? 1'b0 : m_uf);
        last = (mx == HT - 1) && (my == VT - 1);
        if (m_run == 0) begin
            if (en) m_run = 1;
        end else if (!en && last) begin
            m_run = 0; mx = 0; my = 0;
        end else begin
            m_run = en ? 1 : 2;
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        if (act && pif.Pix_Valid) seq = seq + 24'd1;
        @(negedge clk);
        cyc++;
        pif.Pix_Data = seq;
    endtask

    task automatic step_until(input int x, input int y, input int bound);
        int n = 0;
        while (!(mx == x && my == y) && n < bound) begin
            step();
            n++;
        end
        chk("reach_x", px, x);
        chk("reach_y", py, y);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; en = 1'b0; uclr = 1'b0;
        pif.Pix_Data = 24'h0; pif.Pix_Valid = 1'b0;
        seq = 24'h0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", pif.Pix_Ready, 0);
        chk("rst_fs", fs, 0);
        chk("rst_de", de, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_d", dout, 0);
        chk("rst_uf", uf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Held idle: nothing moves.
        fs_count = 0;
        repeat (20) step();
        chk("idle_no_fs", fs_count, 0);

        // Two full frames with continuous valid data.
        pif.Pix_Valid = 1'b1;
        en = 1'b1;
        fs_count = 0;
        step();
        chk("first_fs", fs, 1);
        step();
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
        count_en = 1'b1;
        repeat (240) step();
        count_en = 1'b0;
        chk("de_count", cnt_de, 64);
        chk("hs_low_count", cnt_hs, 48);
        chk("vs_low_count", cnt_vs, 60);
        chk("fs_count", fs_count, 3);
        chk("fs_period", fs_gap, FRAME);

        // Single missing pixel at (5,2).
        step_until(5, 2, 200);
        pif.Pix_Valid = 1'b0;
        step();
        pif.Pix_Valid = 1'b1;
        chk("uf_set", uf, 1);
        chk("uf_de", de, 1);
        chk("uf_data_zero", dout, 0);
        step();
        chk("uf_next_data", dout, seq - 24'd1);

        // Clear coinciding with a new underflow loses; a later clean clear wins.
        uclr = 1'b1; pif.Pix_Valid = 1'b0;
        step();
        uclr = 1'b0; pif.Pix_Valid = 1'b1;
        chk("uf_set_wins", uf, 1);
        uclr = 1'b1;
        step();
        uclr = 1'b0;
        chk("uf_cleared", uf, 0);

        // Stop request mid-frame finishes the frame then idles.
        step_until(0, 3, 200);
        en = 1'b0;
        fs_count = 0;
        n = 0;
        while (m_run != 0 && n < 300) begin
            step();
            n++;
        end
        chk("stop_len", n, 75);
        repeat (5) step();
        chk("stop_no_fs", fs_count, 0);
        chk("stop_px", px, 0);
        chk("stop_py", py, 0);
        chk("stop_de", de, 0);
        chk("stop_hs", hs, 1);
        chk("stop_vs", vs, 1);
        chk("stop_d", dout, 0);
        chk("stop_ready", pif.Pix_Ready, 0);

        // Stop then resume inside the same frame: period unchanged.
        en = 1'b1;
        step();
        step();
        step_until(0, 1, 200);
        en = 1'b0;
        step_until(0, 3, 200);
        en = 1'b1;
        step_until(0, 0, 200);
        step();
        chk("resume_period", fs_gap, FRAME);

        // Asynchronous reset in active video with a pending underflow.
        step_until(2, 1, 200);
        pif.Pix_Valid = 1'b0;
        step();
        pif.Pix_Valid = 1'b1;
        chk("pre_rst_uf", uf, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", pif.Pix_Ready, 0);
        chk("arst_fs", fs, 0);
        chk("arst_px", px, 0);
        chk("arst_py", py, 0);
        chk("arst_de", de, 0);
        chk("arst_hs", hs, 1);
        chk("arst_vs", vs, 1);
        chk("arst_d", dout, 0);
        chk("arst_uf", uf, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("restart_fs", fs, 1);
        chk("restart_px", px, 0);
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adv_video_timing.md
Name: adv_video_timing

Overview:
- Pixel-clock video timing generator and pixel stage that drives the ADV7513 HDMI transmitter (ADV_DE, ADV_Hsync, ADV_Vsync, ADV_D).
- Pulls 24-bit RGB pixels from the upstream framebuffer reader through a valid/ready handshake and places them on registered outputs.
- Counts per-frame timing from parameters.
- Flags underflow when the upstream source cannot keep up.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, Hsync active level (0 = active low)
VS_POL, 0, Vsync active level (0 = active low)

Ports:
Pixel_CLK  input  1  pixel clock; also forwarded to ADV_CLK by the top level
Reset_n  input  1  asynchronous active-low reset
Enable  input  1  run request; level-sensitive
Pix_Data  input  24  upstream RGB pixel, {R,G,B}
Pix_Valid  input  1  Pix_Data valid
Pix_Ready  output  1  block accepts a pixel this cycle
Frame_Start  output  1  one-cycle pulse at counter position (0,0)
Pos_X  output  11  current horizontal counter
Pos_Y  output  10  current vertical counter
Underflow  output  1  sticky: an active pixel was missing
Underflow_Clear  input  1  clears Underflow
ADV_DE  output  1  data enable to ADV7513
ADV_Hsync  output  1  horizontal sync to ADV7513
ADV_Vsync  output  1  vertical sync to ADV7513
ADV_D  output  24  pixel data to ADV7513

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (asynchronous, Reset_n low):
  - State IDLE; counters 0.
  - Pix_Ready=0, Frame_Start=0, Underflow=0, ADV_DE=0, ADV_D=0.
  - ADV_Hsync=!HS_POL, ADV_Vsync=!VS_POL.
- States:
  - IDLE -> RUN on the first clock with Enable=1; counters start at (0,0) that cycle.
  - RUN -> STOPPING when Enable=0.
  - STOPPING -> RUN if Enable returns to 1; the current frame continues unbroken.
  - STOPPING -> IDLE when the counters wrap from (H_TOTAL-1,V_TOTAL-1). Frames are never truncated.
  - IDLE holds the counters at 0 with all outputs at their reset values.
- Counters (RUN and STOPPING):
  - Pos_X increments every clock and wraps at H_TOTAL-1 to 0.
  - Pos_Y increments when Pos_X wraps and itself wraps at V_TOTAL-1 to 0.
  - Pos_X/Pos_Y are the counter registers themselves.
- Combinational, from the counters:
  - active = (Pos_X < H_ACTIVE) && (Pos_Y < V_ACTIVE) && state != IDLE.
  - Pix_Ready = active. A transfer occurs when Pix_Ready && Pix_Valid.
  - Frame_Start = (Pos_X==0 && Pos_Y==0 && state != IDLE), i.e. the same cycle as the first Pix_Ready of the frame.
- Registered, 1-clock latency from the counters:
  - ADV_DE <= active.
  - ADV_Hsync <= HS_POL when H_ACTIVE+H_FP <= Pos_X < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - ADV_Vsync <= VS_POL when V_ACTIVE+V_FP <= Pos_Y < V_ACTIVE+V_FP+V_SYNC (whole lines), else !VS_POL.
  - ADV_D <= Pix_Data on a transfer; 24'h000000 when active without Pix_Valid; 24'h000000 when not active.
- Underflow:
  - Set when active && !Pix_Valid.
  - Cleared by Underflow_Clear.
  - Set wins over a simultaneous clear.
- The upstream source must not be back-pressured outside active video: Pix_Ready=0 there, and Pix_Valid is ignored.
- Counter widths must hold H_TOTAL-1 and V_TOTAL-1. Parameter sets exceeding 11/10 bits are unsupported.

Test Plan:
- Reset then hold Enable=0 for 100 clocks -> ADV_DE=0, ADV_Hsync=1, ADV_Vsync=1, ADV_D=0, Pix_Ready=0, Frame_Start never pulses.
- Enable=1, Pix_Valid=1 with an incrementing Pix_Data -> Frame_Start pulses at enable+0 and again at +420000 clocks.
  - Per line: ADV_DE high 640 clocks starting 1 clock after Pix_Ready.
  - ADV_Hsync low for clocks 657..752 after line start.
  - ADV_Vsync low for lines 490..491.
  - ADV_D equals accepted data in order.
- Pix_Valid=0 for pixel (100,5) only -> ADV_D=0 on that DE cycle, Underflow=1 thereafter, and the following pixel is the next accepted datum.
- Underflow_Clear asserted in the same cycle as a new underflow -> Underflow stays 1. A clear in a later clean cycle -> 0.
- Drop Enable at line 200 -> output continues to (799,524), then IDLE. No Frame_Start follows, and outputs return to their reset values.
- Drop Enable, then re-raise it at line 300 of the same frame -> timing continuous with no glitch, and the next Frame_Start arrives exactly 420000 clocks after the previous one.
- Assert Reset_n low mid-line during active video -> all outputs reach their reset values immediately, asynchronously. After release with Enable=1, the frame restarts at (0,0).
